// File: rtl/timer_loader_if.sv
// timer_loader_if: keypad-side entry signals and timer load bus of timer_loader.
interface timer_loader_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start;
  logic       cancel;
  logic [3:0] data_out;
  logic       loadn;
  logic       busy;
  logic       load_done;
  logic       error;
  logic [3:0] entry_mins;
  logic [3:0] entry_tens;
  logic [3:0] entry_ones;
  logic [1:0] digit_count;
  modport master (
    output key_valid, key_code, start, cancel,
    input  data_out, loadn, busy, load_done, error,
    input  entry_mins, entry_tens, entry_ones, digit_count
  );
  modport slave (
    input  key_valid, key_code, start, cancel,
    output data_out, loadn, busy, load_done, error,
    output entry_mins, entry_tens, entry_ones, digit_count
  );
endinterface

// File: rtl/timer_loader.sv
// timer_loader: buffers a 3-digit m:ss keypad entry and shifts it into the timer with three load strobes.
// Optional macro TIMER_LOADER_CLAMP_EN: clamp an out-of-range entry at start instead of rejecting it.
module timer_loader #(
  parameter logic [3:0] MAX_SEC_TENS = 4'd5,
  parameter logic [3:0] MAX_MINS     = 4'd9
) (
  input logic           clock,
  input logic           clear,
  timer_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_T, LOAD_O, DONE} state_t;
  state_t state;
  // Entry buffer, start validation and the mins->tens->ones load sequence, all outputs registered.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state           <= IDLE;
      bus.entry_mins  <= 4'd0;
      bus.entry_tens  <= 4'd0;
      bus.entry_ones  <= 4'd0;
      bus.digit_count <= 2'd0;
      bus.data_out    <= 4'd0;
      bus.loadn       <= 1'b1;
      bus.busy        <= 1'b0;
      bus.load_done   <= 1'b0;
      bus.error       <= 1'b0;
    end else begin
      bus.load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cancel) begin
            bus.entry_mins  <= 4'd0;
            bus.entry_tens  <= 4'd0;
            bus.entry_ones  <= 4'd0;
            bus.digit_count <= 2'd0;
            bus.error       <= 1'b0;
          end else if (bus.start) begin
            if (bus.digit_count != 2'd0) begin
`ifdef TIMER_LOADER_CLAMP_EN
              // Minutes can only exceed the limit if MAX_MINS is set below 9; clamp it too so the load stays legal.
              if (bus.entry_mins > MAX_MINS) bus.entry_mins <= MAX_MINS;
              if (bus.entry_tens > MAX_SEC_TENS) begin
                bus.entry_tens <= MAX_SEC_TENS;
                bus.entry_ones <= 4'd9;
              end
              state        <= LOAD_M;
              bus.busy     <= 1'b1;
              bus.loadn    <= 1'b0;
              bus.data_out <= (bus.entry_mins > MAX_MINS) ? MAX_MINS : bus.entry_mins;
`else
              if (bus.entry_tens > MAX_SEC_TENS || bus.entry_mins > MAX_MINS) begin
                bus.error <= 1'b1;
              end else begin
                state        <= LOAD_M;
                bus.busy     <= 1'b1;
                bus.loadn    <= 1'b0;
                bus.data_out <= bus.entry_mins;
              end
`endif
            end
          end else if (bus.key_valid && bus.key_code <= 4'd9) begin
            bus.entry_mins  <= bus.entry_tens;
            bus.entry_tens  <= bus.entry_ones;
            bus.entry_ones  <= bus.key_code;
            bus.digit_count <= (bus.digit_count == 2'd3) ? 2'd3 : bus.digit_count + 2'd1;
            bus.error       <= 1'b0;
          end
        end
        LOAD_M: begin
          state        <= LOAD_T;
          bus.data_out <= bus.entry_tens;
        end
        LOAD_T: begin
          state        <= LOAD_O;
          bus.data_out <= bus.entry_ones;
        end
        LOAD_O: begin
          state           <= DONE;
          bus.loadn       <= 1'b1;
          bus.data_out    <= 4'd0;
          bus.busy        <= 1'b0;
          bus.load_done   <= 1'b1;
          bus.entry_mins  <= 4'd0;
          bus.entry_tens  <= 4'd0;
          bus.entry_ones  <= 4'd0;
          bus.digit_count <= 2'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_timer_loader.sv
// tb_timer_loader: vector table, hand-written corner sequences and random run against a queue-based model.
module tb_timer_loader;
  typedef struct packed {
    logic       loadn;
    logic [3:0] dout;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] mins;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [1:0] cnt;
  } out_t;
  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic       st;
    logic       ca;
    out_t       exp;
  } vec_t;
  logic clock = 1'b0;
  logic clear;
  int n_checks = 0;
  int n_fail = 0;
  vec_t tbl[$];
  logic [3:0] hist[$];
  out_t pend[$];
  logic merr;
  timer_loader_if bus();
  timer_loader dut (.clock(clock), .clear(clear), .bus(bus));
  always #5 clock = ~clock;
  function automatic out_t mk(input logic l, input logic [3:0] d, input logic b, input logic dn, input logic e,
                              input logic [3:0] m, input logic [3:0] t, input logic [3:0] o, input logic [1:0] c);
    return {l, d, b, dn, e, m, t, o, c};
  endfunction
  function automatic out_t idl(input logic e, input logic [3:0] m, input logic [3:0] t, input logic [3:0] o, input logic [1:0] c);
    return mk(1'b1, 4'd0, 1'b0, 1'b0, e, m, t, o, c);
  endfunction
  function automatic out_t ld(input logic [3:0] d, input logic [3:0] m, input logic [3:0] t, input logic [3:0] o, input logic [1:0] c);
    return mk(1'b0, d, 1'b1, 1'b0, 1'b0, m, t, o, c);
  endfunction
  function automatic out_t dut_out();
    return {bus.loadn, bus.data_out, bus.busy, bus.load_done, bus.error,
            bus.entry_mins, bus.entry_tens, bus.entry_ones, bus.digit_count};
  endfunction
  function automatic string fmt(input out_t o);
    return $sformatf("loadn=%0d data_out=%0d busy=%0d load_done=%0d error=%0d entry=%0d:%0d%0d count=%0d",
                     o.loadn, o.dout, o.busy, o.done, o.err, o.mins, o.tens, o.ones, o.cnt);
  endfunction
  task automatic check(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    end
  endtask
  task automatic step(input logic kv, input logic [3:0] kc, input logic st, input logic ca);
    bus.key_valid = kv;
    bus.key_code  = kc;
    bus.start     = st;
    bus.cancel    = ca;
    @(posedge clock);
    #1;
  endtask
  task automatic add(input logic kv, input logic [3:0] kc, input logic st, input logic ca, input out_t e);
    tbl.push_back('{kv, kc, st, ca, e});
  endtask
  function automatic out_t idle_out();
    int n;
    n = hist.size();
    return idl(merr, (n >= 3) ? hist[n-3] : 4'd0, (n >= 2) ? hist[n-2] : 4'd0,
               (n >= 1) ? hist[n-1] : 4'd0, (n >= 3) ? 2'd3 : 2'(n));
  endfunction
  function automatic out_t model_step(input logic kv, input logic [3:0] kc, input logic st, input logic ca);
    out_t c;
    logic [3:0] t, o;
    c = idle_out();
    t = c.tens;
    o = c.ones;
    if (pend.size() == 0) begin
      if (ca) begin
        hist.delete();
        merr = 1'b0;
      end else if (st) begin
        if (hist.size() > 0) begin
`ifdef TIMER_LOADER_CLAMP_EN
          if (t > 4'd5) begin
            t = 4'd5;
            o = 4'd9;
          end
`endif
          if (t > 4'd5 || c.mins > 4'd9) merr = 1'b1;
          else begin
            pend.push_back(ld(c.mins, c.mins, t, o, c.cnt));
            pend.push_back(ld(t, c.mins, t, o, c.cnt));
            pend.push_back(ld(o, c.mins, t, o, c.cnt));
            pend.push_back(mk(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 2'd0));
            pend.push_back(idl(1'b0, 4'd0, 4'd0, 4'd0, 2'd0));
            hist.delete();
          end
        end
      end else if (kv && kc <= 4'd9) begin
        hist.push_back(kc);
        if (hist.size() > 3) void'(hist.pop_front());
        merr = 1'b0;
      end
    end
    return (pend.size() > 0) ? pend.pop_front() : idle_out();
  endfunction
  initial begin
    out_t rst, z, e;
    rst = idl(1'b0, 4'd0, 4'd0, 4'd0, 2'd0);
    z = rst;
    clear = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code = 4'd0;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    #12;
    check("reset", dut_out(), rst);
    clear = 1'b1;
    add(1, 1, 0, 0, idl(0, 0, 0, 1, 1));
    add(1, 3, 0, 0, idl(0, 0, 1, 3, 2));
    add(1, 0, 0, 0, idl(0, 1, 3, 0, 3));
    add(0, 0, 1, 0, ld(1, 1, 3, 0, 3));
    add(0, 0, 0, 0, ld(3, 1, 3, 0, 3));
    add(0, 0, 0, 0, ld(0, 1, 3, 0, 3));
    add(0, 0, 0, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, z);
    add(1, 4, 0, 0, idl(0, 0, 0, 4, 1));
    add(1, 2, 0, 0, idl(0, 0, 4, 2, 2));
    add(1, 5, 0, 0, idl(0, 4, 2, 5, 3));
    add(1, 9, 0, 0, idl(0, 2, 5, 9, 3));
    add(1, 10, 0, 0, idl(0, 2, 5, 9, 3));
    add(0, 0, 1, 0, ld(2, 2, 5, 9, 3));
    add(0, 0, 0, 0, ld(5, 2, 5, 9, 3));
    add(0, 0, 0, 0, ld(9, 2, 5, 9, 3));
    add(0, 0, 0, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, z);
    add(1, 12, 0, 0, z);
    add(0, 0, 1, 0, z);
    add(1, 1, 0, 0, idl(0, 0, 0, 1, 1));
    add(1, 7, 0, 0, idl(0, 0, 1, 7, 2));
    add(1, 5, 0, 0, idl(0, 1, 7, 5, 3));
`ifdef TIMER_LOADER_CLAMP_EN
    add(0, 0, 1, 0, ld(1, 1, 5, 9, 3));
    add(0, 0, 0, 0, ld(5, 1, 5, 9, 3));
    add(0, 0, 0, 0, ld(9, 1, 5, 9, 3));
    add(0, 0, 0, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, z);
`else
    add(0, 0, 1, 0, idl(1, 1, 7, 5, 3));
    add(0, 0, 0, 0, idl(1, 1, 7, 5, 3));
    add(1, 3, 0, 0, idl(0, 7, 5, 3, 3));
    add(0, 0, 0, 1, z);
`endif
    add(1, 2, 0, 0, idl(0, 0, 0, 2, 1));
    add(1, 4, 1, 0, ld(0, 0, 0, 2, 1));
    add(0, 0, 0, 0, ld(0, 0, 0, 2, 1));
    add(0, 0, 0, 0, ld(2, 0, 0, 2, 1));
    add(0, 0, 0, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, z);
    add(1, 5, 0, 0, idl(0, 0, 0, 5, 1));
    add(1, 6, 1, 1, z);
    add(0, 0, 0, 0, z);
    foreach (tbl[i]) begin
      step(tbl[i].kv, tbl[i].kc, tbl[i].st, tbl[i].ca);
      check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end
    step(1, 1, 0, 0);
    step(1, 3, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    check("busy_start", dut_out(), ld(1, 1, 3, 0, 3));
    step(1, 8, 1, 1);
    check("ignore_load_t", dut_out(), ld(3, 1, 3, 0, 3));
    step(1, 8, 1, 1);
    check("ignore_load_o", dut_out(), ld(0, 1, 3, 0, 3));
    step(1, 8, 1, 1);
    check("ignore_done", dut_out(), mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    step(1, 8, 1, 1);
    check("ignore_after_done", dut_out(), z);
    step(1, 2, 0, 0);
    step(1, 4, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("mid_load_t", dut_out(), ld(4, 2, 4, 1, 3));
    #3;
    clear = 1'b0;
    #1;
    check("clear_async", dut_out(), rst);
    @(posedge clock);
    #1;
    check("clear_held", dut_out(), rst);
    #2;
    clear = 1'b1;
    step(0, 0, 0, 0);
    check("after_clear", dut_out(), z);
    hist.delete();
    pend.delete();
    merr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic kv, st, ca;
      logic [3:0] kc;
      kv = 1'($urandom_range(0, 1));
      kc = 4'($urandom_range(0, 15));
      st = ($urandom_range(0, 6) == 0);
      ca = ($urandom_range(0, 24) == 0);
      e = model_step(kv, kc, st, ca);
      step(kv, kc, st, ca);
      check($sformatf("rand%0d", i), dut_out(), e);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
